// File: rtl/byte_packer_pkg.sv
// rtl/byte_packer_pkg.sv - shared packer_pkg: FILL/FULL encodings, slot geometry, slot-insert helper
package packer_pkg;

  // Width of one byte slot and the number of slots in an output word
  localparam int SLOT_W = 8;
  localparam int SLOTS  = 4;
  localparam int WORD_W = SLOT_W * SLOTS;
  localparam int IDX_W  = 2;

  // Index of the slot whose write completes a word
  localparam logic [IDX_W-1:0] LAST_IDX = 2'd3;

  // FILL: 0..3 bytes held, no word offered. FULL: a word is offered and held.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } packer_state_e;

  // Returns word with byte b written into slot idx. Slot 0 is the first byte
  // of a word: it lands in the top byte lane when lsb_first is 0 and in the
  // bottom lane when lsb_first is 1. For a 2-bit index, 3-idx equals ~idx.
  function automatic logic [WORD_W-1:0] put_slot(
    input logic [WORD_W-1:0] word,
    input logic [IDX_W-1:0]  idx,
    input logic [SLOT_W-1:0] b,
    input bit                lsb_first
  );
    logic [WORD_W-1:0] r;
    logic [IDX_W-1:0]  lane;
    r    = word;
    lane = lsb_first ? idx : ~idx;
    case (lane)
      2'd0:    r[0*SLOT_W +: SLOT_W] = b;
      2'd1:    r[1*SLOT_W +: SLOT_W] = b;
      2'd2:    r[2*SLOT_W +: SLOT_W] = b;
      default: r[3*SLOT_W +: SLOT_W] = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/byte_packer_if.sv
// rtl/byte_packer_if.sv - byte-in / word-out handshake bundle; flush and out_bytes exist under BYTE_PACKER_FLUSH_EN
interface byte_packer_if;
  import packer_pkg::*;

  logic [SLOT_W-1:0] in_byte;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] out_word;
  logic              out_valid;
  logic              out_ready;
`ifdef BYTE_PACKER_FLUSH_EN
  logic              flush;
  logic [2:0]        out_bytes;
`endif

  // Producer/consumer side: supplies bytes, takes words
  modport master (
    output in_byte, in_valid, out_ready,
`ifdef BYTE_PACKER_FLUSH_EN
    output flush,
    input  out_bytes,
`endif
    input  in_ready, out_word, out_valid
  );

  // Packer side
  modport slave (
    input  in_byte, in_valid, out_ready,
`ifdef BYTE_PACKER_FLUSH_EN
    input  flush,
    output out_bytes,
`endif
    output in_ready, out_word, out_valid
  );

endinterface

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs four bytes into a 32-bit word with valid/ready on both sides; BYTE_PACKER_FLUSH_EN adds partial-word flush
module byte_packer
  import packer_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  byte_packer_if.slave  bus
);

  packer_state_e     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              in_xfer;
`ifdef BYTE_PACKER_FLUSH_EN
  logic [2:0]        bytes_q, bytes_d;
`endif

  // A held word blocks input unless the consumer takes it this same cycle,
  // which lets a new word start with no bubble.
  assign bus.in_ready  = (state_q != FULL) || bus.out_ready;
  assign bus.out_valid = (state_q == FULL);
  assign bus.out_word  = word_q;
  assign in_xfer       = bus.in_valid && bus.in_ready;
`ifdef BYTE_PACKER_FLUSH_EN
  assign bus.out_bytes = bytes_q;
`endif

  // State, slot index, word and byte-count registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      word_q  <= '0;
`ifdef BYTE_PACKER_FLUSH_EN
      bytes_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
`ifdef BYTE_PACKER_FLUSH_EN
      bytes_q <= bytes_d;
`endif
    end
  end

  // Next-state: fill slots in order, offer the word when slot 3 (or a flush)
  // closes it, and clear all slots when the word is taken.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
`ifdef BYTE_PACKER_FLUSH_EN
    bytes_d = bytes_q;
`endif
    case (state_q)
      FILL: begin
        if (in_xfer) begin
          word_d = put_slot(word_q, idx_q, bus.in_byte, LSB_FIRST);
          idx_d  = idx_q + 2'd1;
          if (idx_q == LAST_IDX) begin
            state_d = FULL;
`ifdef BYTE_PACKER_FLUSH_EN
            bytes_d = 3'd4;
`endif
          end
        end
`ifdef BYTE_PACKER_FLUSH_EN
        // A flush closes a non-empty partial word; untouched slots are
        // already zero because slots are cleared on every delivery.
        if (bus.flush && (state_d == FILL) && ((idx_q != '0) || in_xfer)) begin
          state_d = FULL;
          idx_d   = '0;
          bytes_d = {1'b0, idx_q} + {2'b00, in_xfer};
        end
`endif
      end
      FULL: begin
        if (bus.out_ready) begin
          state_d = FILL;
          idx_d   = '0;
          word_d  = '0;
`ifdef BYTE_PACKER_FLUSH_EN
          bytes_d = '0;
`endif
          if (in_xfer) begin
            word_d = put_slot('0, '0, bus.in_byte, LSB_FIRST);
            idx_d  = 2'd1;
          end
        end
      end
      default: begin
        state_d = FILL;
        idx_d   = '0;
        word_d  = '0;
      end
    endcase
  end

endmodule
